// File: rtl/sram_test_sequencer_if.sv
// Command, read-return and checker-feed signals for the SRAM test sequencer.
// master = sequencer side; slave = controller/checker side.
interface sram_test_sequencer_if #(
   parameter int unsigned ADDR_BITS = 20,
   parameter int unsigned DATA_BITS = 16
);
   logic                 cmd_valid;
   logic                 cmd_ready;
   logic                 cmd_we;
   logic [ADDR_BITS-1:0] cmd_addr;
   logic [DATA_BITS-1:0] cmd_wdata;
   logic                 rd_valid;
   logic [DATA_BITS-1:0] rd_data;
   logic                 chk_enable;
   logic [DATA_BITS-1:0] chk_read_data;
   logic [DATA_BITS-1:0] chk_expected_data;

   modport master (
      output cmd_valid, cmd_we, cmd_addr, cmd_wdata,
      output chk_enable, chk_read_data, chk_expected_data,
      input  cmd_ready, rd_valid, rd_data
   );

   modport slave (
      input  cmd_valid, cmd_we, cmd_addr, cmd_wdata,
      input  chk_enable, chk_read_data, chk_expected_data,
      output cmd_ready, rd_valid, rd_data
   );
endinterface

// File: rtl/sram_test_sequencer.sv
// SRAM test pass sequencer: pattern write sweep, read sweep, and in-order
// pairing of returned data with regenerated expected data for the checker.
module sram_test_sequencer #(
   parameter int unsigned          ADDR_BITS = 20,
   parameter int unsigned          DATA_BITS = 16,
   parameter logic [DATA_BITS-1:0] SEED      = DATA_BITS'(16'hA5C3),
   parameter int unsigned          ITER_BITS = 16
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic                  loop,
   sram_test_sequencer_if.master bus,
   output logic                  busy,
   output logic                  iter_done,
   output logic [ITER_BITS-1:0]  iter_count
);

   typedef enum logic [1:0] {S_IDLE, S_WRITE, S_READ, S_DRAIN} state_t;

   localparam logic [ADDR_BITS-1:0] ADDR_ONE = ADDR_BITS'(1);
   localparam logic [ITER_BITS-1:0] ITER_ONE = ITER_BITS'(1);

   state_t               r_state;
   logic [ADDR_BITS-1:0] r_cmd_addr;
   logic [ADDR_BITS-1:0] r_ret_addr;
   logic [DATA_BITS-1:0] r_seed;
   logic [ITER_BITS-1:0] r_iter_count;
   logic                 r_cmd_valid;
   logic                 r_cmd_we;
   logic [DATA_BITS-1:0] r_cmd_wdata;
   logic                 r_chk_enable;
   logic [DATA_BITS-1:0] r_chk_read_data;
   logic [DATA_BITS-1:0] r_chk_expected_data;
   logic                 r_busy;
   logic                 r_iter_done;

   logic                 w_xfer;
   logic                 w_last_cmd;
   logic                 w_ret;
   logic                 w_ret_last;
   logic [ADDR_BITS-1:0] w_next_addr;

   function automatic logic [DATA_BITS-1:0] pat(input logic [ADDR_BITS-1:0] a,
                                                input logic [DATA_BITS-1:0] s);
      return DATA_BITS'(a) ^ s;
   endfunction

   assign w_xfer      = r_cmd_valid & bus.cmd_ready;
   assign w_last_cmd  = w_xfer & (r_cmd_addr == '1);
   assign w_ret       = bus.rd_valid & ((r_state == S_READ) | (r_state == S_DRAIN));
   assign w_ret_last  = w_ret & (r_ret_addr == '1);
   assign w_next_addr = r_cmd_addr + ADDR_ONE;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state             <= S_IDLE;
         r_cmd_addr          <= '0;
         r_ret_addr          <= '0;
         r_seed              <= SEED;
         r_iter_count        <= '0;
         r_cmd_valid         <= 1'b0;
         r_cmd_we            <= 1'b0;
         r_cmd_wdata         <= '0;
         r_chk_enable        <= 1'b0;
         r_chk_read_data     <= '0;
         r_chk_expected_data <= '0;
         r_busy              <= 1'b0;
         r_iter_done         <= 1'b0;
      end else begin
         r_chk_enable <= 1'b0;
         r_iter_done  <= 1'b0;

         if (w_ret) begin
            r_chk_enable        <= 1'b1;
            r_chk_read_data     <= bus.rd_data;
            r_chk_expected_data <= pat(r_ret_addr, r_seed);
            r_ret_addr          <= r_ret_addr + ADDR_ONE;
         end

         unique case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_state      <= S_WRITE;
                  r_busy       <= 1'b1;
                  r_iter_count <= '0;
                  r_seed       <= SEED;
                  r_ret_addr   <= '0;
                  r_cmd_valid  <= 1'b1;
                  r_cmd_we     <= 1'b1;
                  r_cmd_addr   <= '0;
                  r_cmd_wdata  <= pat('0, SEED);
               end
            end
            S_WRITE: begin
               if (w_last_cmd) begin
                  r_state     <= S_READ;
                  r_cmd_we    <= 1'b0;
                  r_cmd_addr  <= '0;
                  r_cmd_wdata <= '0;
               end else if (w_xfer) begin
                  r_cmd_addr  <= w_next_addr;
                  r_cmd_wdata <= pat(w_next_addr, r_seed);
               end
            end
            S_READ: begin
               if (w_last_cmd) begin
                  r_state     <= S_DRAIN;
                  r_cmd_valid <= 1'b0;
                  r_cmd_addr  <= '0;
               end else if (w_xfer) begin
                  r_cmd_addr <= w_next_addr;
               end
            end
            S_DRAIN: begin
            end
            default: r_state <= S_IDLE;
         endcase

         // Iteration end overrides the READ->DRAIN step so a last return that
         // coincides with the last read transfer skips DRAIN entirely.
         if (w_ret_last) begin
            r_iter_done  <= 1'b1;
            r_iter_count <= r_iter_count + ITER_ONE;
            r_seed       <= ~r_seed;
            r_ret_addr   <= '0;
            if (loop) begin
               r_state     <= S_WRITE;
               r_cmd_valid <= 1'b1;
               r_cmd_we    <= 1'b1;
               r_cmd_addr  <= '0;
               r_cmd_wdata <= pat('0, ~r_seed);
            end else begin
               r_state     <= S_IDLE;
               r_busy      <= 1'b0;
               r_cmd_valid <= 1'b0;
            end
         end
      end
   end

   assign bus.cmd_valid         = r_cmd_valid;
   assign bus.cmd_we            = r_cmd_we;
   assign bus.cmd_addr          = r_cmd_addr;
   assign bus.cmd_wdata         = r_cmd_wdata;
   assign bus.chk_enable        = r_chk_enable;
   assign bus.chk_read_data     = r_chk_read_data;
   assign bus.chk_expected_data = r_chk_expected_data;
   assign busy                  = r_busy;
   assign iter_done             = r_iter_done;
   assign iter_count            = r_iter_count;

endmodule

// File: tb/tb_sram_test_sequencer.sv
// Directed bench for sram_test_sequencer: 8-word SRAM model with selectable
// read latency, optional cmd_ready throttling and a corruptible address.
module tb_sram_test_sequencer;
   localparam int unsigned AB = 3;
   localparam int unsigned DB = 8;
   localparam logic [7:0] P0 [8] = '{8'h5A, 8'h5B, 8'h58, 8'h59, 8'h5E, 8'h5F, 8'h5C, 8'h5D};
   localparam logic [7:0] P1 [8] = '{8'hA5, 8'hA4, 8'hA7, 8'hA6, 8'hA1, 8'hA0, 8'hA3, 8'hA2};

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        start = 1'b0;
   logic        loop = 1'b0;
   logic        busy;
   logic        iter_done;
   logic [15:0] iter_count;

   sram_test_sequencer_if #(.ADDR_BITS(AB), .DATA_BITS(DB)) bus ();

   sram_test_sequencer #(
      .ADDR_BITS(AB), .DATA_BITS(DB), .SEED(8'h5A), .ITER_BITS(16)
   ) dut (
      .clk(clk), .reset(reset), .start(start), .loop(loop), .bus(bus),
      .busy(busy), .iter_done(iter_done), .iter_count(iter_count)
   );

   always #5 clk = ~clk;

   // memory model
   int unsigned lat = 2;
   logic        corrupt_en = 1'b0;
   logic        rand_ready = 1'b0;
   logic [7:0]  mem [8];
   logic [3:0]  pv = '0;
   logic [7:0]  pd [4];
   logic        w_rd_xfer;
   logic [7:0]  w_rd_word;

   always_comb w_rd_xfer = (bus.cmd_valid & bus.cmd_ready & ~bus.cmd_we) === 1'b1;
   always_comb w_rd_word = (corrupt_en && bus.cmd_addr == 3'd3) ? 8'h00 : mem[bus.cmd_addr];
   always_comb begin
      bus.rd_valid = 1'b0;
      bus.rd_data  = '0;
      if (lat == 0) begin
         bus.rd_valid = w_rd_xfer;
         bus.rd_data  = w_rd_word;
      end else begin
         bus.rd_valid = pv[lat-1];
         bus.rd_data  = pd[lat-1];
      end
   end

   always @(posedge clk) begin
      pv    <= {pv[2:0], w_rd_xfer};
      pd[0] <= w_rd_word;
      for (int k = 1; k < 4; k++) pd[k] <= pd[k-1];
      if ((bus.cmd_valid & bus.cmd_ready & bus.cmd_we) === 1'b1) mem[bus.cmd_addr] <= bus.cmd_wdata;
   end

   always @(posedge clk) begin
      #2;
      bus.cmd_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
   end

   // monitor: logs transfers, checker pulses and iteration ends
   logic        lw [512];
   logic [2:0]  la [512];
   logic [7:0]  ld [512];
   logic [7:0]  cr [512];
   logic [7:0]  ce [512];
   int unsigned n_x = 0, n_c = 0, n_d = 0, n_rx = 0, n_unst = 0;
   int unsigned cyc = 0, t_last = 0, t_done = 0;
   logic        p_stall = 1'b0, p_we = 1'b0;
   logic [2:0]  p_addr = '0;
   logic [7:0]  p_data = '0;

   always @(negedge clk) begin
      cyc <= cyc + 1;
      if ((bus.cmd_valid & bus.cmd_ready) === 1'b1 && n_x < 512) begin
         lw[n_x] <= bus.cmd_we;
         la[n_x] <= bus.cmd_addr;
         ld[n_x] <= bus.cmd_wdata;
         n_x     <= n_x + 1;
         if (!bus.cmd_we) begin
            n_rx <= n_rx + 1;
            if (bus.cmd_addr == 3'd7) t_last <= cyc;
         end
      end
      if (bus.chk_enable === 1'b1 && n_c < 512) begin
         cr[n_c] <= bus.chk_read_data;
         ce[n_c] <= bus.chk_expected_data;
         n_c     <= n_c + 1;
      end
      if (iter_done === 1'b1) begin
         n_d    <= n_d + 1;
         t_done <= cyc;
      end
      if (p_stall && !reset &&
          (bus.cmd_valid !== 1'b1 || bus.cmd_we !== p_we || bus.cmd_addr !== p_addr || bus.cmd_wdata !== p_data))
         n_unst <= n_unst + 1;
      p_stall <= (bus.cmd_valid & ~bus.cmd_ready) === 1'b1;
      p_we    <= bus.cmd_we;
      p_addr  <= bus.cmd_addr;
      p_data  <= bus.cmd_wdata;
   end

   int unsigned n_vec = 0;
   int unsigned n_err = 0;

   task automatic pulse_start();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_done(input int unsigned target, input logic need_idle, input string name);
      int unsigned k = 0;
      while ((n_d < target || (need_idle && busy !== 1'b0)) && k < 400) begin
         @(negedge clk);
         k++;
      end
      @(negedge clk);
      n_vec++;
      if (k >= 400) begin
         n_err++;
         $display("FAIL %s_timeout: iter_done count %0d busy %b, required %0d", name, n_d, busy, target);
      end
   endtask

   task automatic test_reset();
      repeat (3) @(negedge clk);
      n_vec++;
      if ({bus.cmd_valid, bus.chk_enable, iter_done, busy} !== 4'b0000) begin
         n_err++;
         $display("FAIL reset_flags: got %b%b%b%b, required 0000", bus.cmd_valid, bus.chk_enable, iter_done, busy);
      end
      n_vec++;
      if (iter_count !== 16'd0) begin
         n_err++;
         $display("FAIL reset_iter_count: got %0d, required 0", iter_count);
      end
      n_vec++;
      if ({bus.cmd_addr, bus.cmd_wdata, bus.chk_read_data, bus.chk_expected_data} !== 27'd0) begin
         n_err++;
         $display("FAIL reset_data: got addr %h wdata %h rd %h exp %h, required all 0",
                  bus.cmd_addr, bus.cmd_wdata, bus.chk_read_data, bus.chk_expected_data);
      end
      reset = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_single_pass();
      int unsigned bx = n_x, bc = n_c, bd = n_d;
      lat = 2; loop = 1'b0;
      pulse_start();
      wait_done(bd + 1, 1'b1, "single");
      n_vec++;
      if (n_x - bx !== 16 || n_c - bc !== 8 || n_d - bd !== 1) begin
         n_err++;
         $display("FAIL single_counts: xfers %0d chk %0d done %0d, required 16 8 1", n_x - bx, n_c - bc, n_d - bd);
      end
      for (int i = 0; i < 16; i++) begin
         n_vec++;
         if ({lw[bx+i], la[bx+i], ld[bx+i]} !== {(i < 8), 3'(i % 8), (i < 8) ? P0[i%8] : 8'h00}) begin
            n_err++;
            $display("FAIL single_cmd%0d: we %b addr %0d data %h, required we %b addr %0d data %h",
                     i, lw[bx+i], la[bx+i], ld[bx+i], (i < 8), i % 8, (i < 8) ? P0[i%8] : 8'h00);
         end
      end
      for (int i = 0; i < 8; i++) begin
         n_vec++;
         if (cr[bc+i] !== P0[i] || ce[bc+i] !== P0[i]) begin
            n_err++;
            $display("FAIL single_chk%0d: read %h expected %h, required both %h", i, cr[bc+i], ce[bc+i], P0[i]);
         end
      end
      n_vec++;
      if (iter_count !== 16'd1 || busy !== 1'b0) begin
         n_err++;
         $display("FAIL single_end: iter_count %0d busy %b, required 1 and 0", iter_count, busy);
      end
   endtask

   task automatic test_loop();
      int unsigned bx = n_x, bc = n_c, bd = n_d;
      lat = 2; loop = 1'b1;
      pulse_start();
      wait_done(bd + 1, 1'b0, "loop_first");
      loop = 1'b0;
      n_vec++;
      if (busy !== 1'b1 || iter_count !== 16'd1) begin
         n_err++;
         $display("FAIL loop_mid: busy %b iter_count %0d, required 1 and 1", busy, iter_count);
      end
      wait_done(bd + 2, 1'b1, "loop_second");
      n_vec++;
      if (n_x - bx !== 32 || n_c - bc !== 16 || iter_count !== 16'd2) begin
         n_err++;
         $display("FAIL loop_counts: xfers %0d chk %0d iter_count %0d, required 32 16 2", n_x - bx, n_c - bc, iter_count);
      end
      for (int i = 0; i < 8; i++) begin
         n_vec++;
         if ({lw[bx+16+i], la[bx+16+i], ld[bx+16+i]} !== {1'b1, 3'(i), P1[i]}) begin
            n_err++;
            $display("FAIL loop_wr%0d: we %b addr %0d data %h, required 1 %0d %h",
                     i, lw[bx+16+i], la[bx+16+i], ld[bx+16+i], i, P1[i]);
         end
         n_vec++;
         if (cr[bc+8+i] !== P1[i] || ce[bc+8+i] !== P1[i]) begin
            n_err++;
            $display("FAIL loop_chk%0d: read %h expected %h, required both %h", i, cr[bc+8+i], ce[bc+8+i], P1[i]);
         end
      end
   endtask

   task automatic test_backpressure();
      int unsigned bx = n_x, bd = n_d, bu = n_unst;
      lat = 2; loop = 1'b0; rand_ready = 1'b1;
      pulse_start();
      wait_done(bd + 1, 1'b1, "bp");
      rand_ready = 1'b0;
      n_vec++;
      if (n_unst - bu !== 0) begin
         n_err++;
         $display("FAIL bp_stable: %0d unstable stall cycles, required 0", n_unst - bu);
      end
      n_vec++;
      if (n_x - bx !== 16) begin
         n_err++;
         $display("FAIL bp_count: %0d transfers, required 16", n_x - bx);
      end
      for (int i = 0; i < 16; i++) begin
         n_vec++;
         if ({lw[bx+i], la[bx+i]} !== {(i < 8), 3'(i % 8)}) begin
            n_err++;
            $display("FAIL bp_order%0d: we %b addr %0d, required %b %0d", i, lw[bx+i], la[bx+i], (i < 8), i % 8);
         end
      end
   endtask

   task automatic test_corrupt();
      int unsigned bc = n_c, bd = n_d, bad = 0;
      lat = 2; loop = 1'b0; corrupt_en = 1'b1;
      pulse_start();
      wait_done(bd + 1, 1'b1, "corrupt");
      corrupt_en = 1'b0;
      n_vec++;
      if (ce[bc+3] !== 8'h59 || cr[bc+3] !== 8'h00) begin
         n_err++;
         $display("FAIL corrupt_chk3: expected %h read %h, required 59 and 00", ce[bc+3], cr[bc+3]);
      end
      for (int i = 0; i < 8; i++) if (cr[bc+i] !== ce[bc+i]) bad++;
      n_vec++;
      if (bad !== 1 || n_c - bc !== 8) begin
         n_err++;
         $display("FAIL corrupt_count: %0d mismatching pairs of %0d, required 1 of 8", bad, n_c - bc);
      end
   endtask

   task automatic test_reset_mid();
      int unsigned br = n_rx, bc, bd, k = 0;
      lat = 2; loop = 1'b0;
      pulse_start();
      while (n_rx < br + 3 && k < 200) begin
         @(negedge clk);
         k++;
      end
      reset = 1'b1;
      @(negedge clk);
      n_vec++;
      if ({bus.cmd_valid, bus.chk_enable, busy} !== 3'b000 || k >= 200) begin
         n_err++;
         $display("FAIL midreset_outputs: valid %b chk %b busy %b wait %0d, required 000 within 200",
                  bus.cmd_valid, bus.chk_enable, busy, k);
      end
      reset = 1'b0;
      bc = n_c;
      repeat (6) @(negedge clk);
      n_vec++;
      if (n_c - bc !== 0) begin
         n_err++;
         $display("FAIL midreset_stale: %0d chk pulses after reset, required 0", n_c - bc);
      end
      bc = n_c; bd = n_d;
      pulse_start();
      wait_done(bd + 1, 1'b1, "midreset_rerun");
      for (int i = 0; i < 8; i++) begin
         n_vec++;
         if (cr[bc+i] !== P0[i] || ce[bc+i] !== P0[i]) begin
            n_err++;
            $display("FAIL midreset_chk%0d: read %h expected %h, required both %h", i, cr[bc+i], ce[bc+i], P0[i]);
         end
      end
      n_vec++;
      if (iter_count !== 16'd1 || n_c - bc !== 8) begin
         n_err++;
         $display("FAIL midreset_end: iter_count %0d chk %0d, required 1 and 8", iter_count, n_c - bc);
      end
   endtask

   task automatic test_zero_latency();
      int unsigned bx = n_x, bc = n_c, bd = n_d;
      lat = 0; loop = 1'b0;
      pulse_start();
      repeat (4) @(negedge clk);
      pulse_start();
      wait_done(bd + 1, 1'b1, "zero");
      n_vec++;
      if (t_done - t_last !== 1) begin
         n_err++;
         $display("FAIL zero_drain: iter_done %0d cycles after last read, required 1", t_done - t_last);
      end
      n_vec++;
      if (n_x - bx !== 16 || n_d - bd !== 1 || n_c - bc !== 8) begin
         n_err++;
         $display("FAIL zero_counts: xfers %0d done %0d chk %0d, required 16 1 8", n_x - bx, n_d - bd, n_c - bc);
      end
      for (int i = 0; i < 16; i++) begin
         n_vec++;
         if ({lw[bx+i], la[bx+i]} !== {(i < 8), 3'(i % 8)}) begin
            n_err++;
            $display("FAIL zero_order%0d: we %b addr %0d, required %b %0d", i, lw[bx+i], la[bx+i], (i < 8), i % 8);
         end
      end
      for (int i = 0; i < 8; i++) begin
         n_vec++;
         if (cr[bc+i] !== P0[i] || ce[bc+i] !== P0[i]) begin
            n_err++;
            $display("FAIL zero_chk%0d: read %h expected %h, required both %h", i, cr[bc+i], ce[bc+i], P0[i]);
         end
      end
   endtask

   initial begin
      test_reset();
      test_single_pass();
      test_loop();
      test_backpressure();
      test_corrupt();
      test_reset_mid();
      test_zero_latency();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not complete, required completion before 400000");
      $fatal(1, "watchdog expired");
   end
endmodule
